zerosoc_gpio_side: RTL and testbench

//  Per-side GPIO controller inside asic_core, directly upstream of one padring side (no/so/ea/we).

---
 rtl/zerosoc_gpio_pkg.sv | 36 +++
 rtl/zerosoc_gpio_side_if.sv | 33 +++
 rtl/zerosoc_gpio_filter.sv | 62 ++++++
 rtl/zerosoc_gpio_side.sv | 156 +++++++++++++++
 tb/tb_zerosoc_gpio_side.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/zerosoc_gpio_pkg.sv
// Shared constants for the per-side GPIO controller: register map, bus widths, reset values.
package zerosoc_gpio_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_OUT       = 5'h00;
  localparam logic [ADDR_W-1:0] ADDR_OEN       = 5'h01;
  localparam logic [ADDR_W-1:0] ADDR_IE        = 5'h02;
  localparam logic [ADDR_W-1:0] ADDR_IN        = 5'h03;
  localparam logic [ADDR_W-1:0] ADDR_RISE_EN   = 5'h04;
  localparam logic [ADDR_W-1:0] ADDR_FALL_EN   = 5'h05;
  localparam logic [ADDR_W-1:0] ADDR_STATUS    = 5'h06;
  localparam logic [ADDR_W-1:0] ADDR_TECH_BASE = 5'h08;

  // Pads come out of reset tristated (oen is active-low).
  localparam logic OEN_RESET_BIT = 1'b1;

  typedef enum logic [1:0] {
    BUS_IDLE  = 2'd0,
    BUS_WRITE = 2'd1,
    BUS_READ  = 2'd2
  } bus_op_e;

  function automatic bus_op_e busOp(input logic valid, input logic write);
    if (!valid) begin
      return BUS_IDLE;
    end
    return write ? BUS_WRITE : BUS_READ;
  endfunction

  function automatic logic [ADDR_W-1:0] techAddr(input int unsigned pad);
    return ADDR_TECH_BASE + ADDR_W'(pad);
  endfunction

endpackage

// File: rtl/zerosoc_gpio_side_if.sv
// Register bus between the core interconnect and one GPIO side controller.
interface zerosoc_gpio_side_if;
  import zerosoc_gpio_pkg::*;

  logic              reg_valid;
  logic              reg_write;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_ready;
  logic              reg_rvalid;
  logic [DATA_W-1:0] reg_rdata;

  modport master (
    output reg_valid,
    output reg_write,
    output reg_addr,
    output reg_wdata,
    input  reg_ready,
    input  reg_rvalid,
    input  reg_rdata
  );

  modport slave (
    input  reg_valid,
    input  reg_write,
    input  reg_addr,
    input  reg_wdata,
    output reg_ready,
    output reg_rvalid,
    output reg_rdata
  );

endinterface

// File: rtl/zerosoc_gpio_filter.sv
// One pad input: 2-flop synchroniser, plus a stability debouncer when GPIO_DEBOUNCE_EN is defined.
module zerosoc_gpio_filter #(
  parameter int DB_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic filt_o
);

  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CNT_W = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             filt_q;
  logic             filt_d;

  // The filtered value only follows the synced input once it has disagreed for DB_CYC straight cycles.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_W'(DB_CYC - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o = filt_q;
`else
  localparam int unused_db_cyc = DB_CYC;

  assign filt_o = sync2_q;
`endif

endmodule

// File: rtl/zerosoc_gpio_side.sv
// GPIO controller for one padring side: pad output registers, input sync, edge interrupt.
// Optional input debounce is enabled by defining GPIO_DEBOUNCE_EN.
module zerosoc_gpio_side
  import zerosoc_gpio_pkg::*;
#(
  parameter int N      = 9,
  parameter int CFGW   = 16,
  parameter int DB_CYC = 4
) (
  input  logic                clk,
  input  logic                rst,
  zerosoc_gpio_side_if.slave  bus,
  input  logic [N-1:0]        pad_din,
  output logic [N-1:0]        pad_dout,
  output logic [N-1:0]        pad_oen,
  output logic [N-1:0]        pad_ie,
  output logic [N*CFGW-1:0]   pad_tech_cfg,
  output logic                irq
);

  logic [N-1:0]      out_q;
  logic [N-1:0]      oen_q;
  logic [N-1:0]      ie_q;
  logic [N-1:0]      riseEn_q;
  logic [N-1:0]      fallEn_q;
  logic [N-1:0]      status_q;
  logic [N-1:0]      status_d;
  logic [N-1:0]      prev_q;
  logic              irq_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;
  logic [CFGW-1:0]   techCfg_q [N];

  bus_op_e           op;
  logic [N-1:0]      wdataN;
  logic [N-1:0]      filt;
  logic [N-1:0]      inVal;
  logic [N-1:0]      rise;
  logic [N-1:0]      fall;
  logic [N-1:0]      stSet;
  logic [N-1:0]      stClr;

  assign op     = busOp(bus.reg_valid, bus.reg_write);
  assign wdataN = bus.reg_wdata[N-1:0];

  for (genvar gi = 0; gi < N; gi++) begin : g_pin
    zerosoc_gpio_filter #(
      .DB_CYC (DB_CYC)
    ) u_filter (
      .clk    (clk),
      .rst    (rst),
      .din_i  (pad_din[gi]),
      .filt_o (filt[gi])
    );

    assign pad_tech_cfg[gi*CFGW +: CFGW] = techCfg_q[gi];
  end

  localparam int USED_W = (N > CFGW) ? N : CFGW;
  if (USED_W < DATA_W) begin : g_unused_wdata
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^bus.reg_wdata[DATA_W-1:USED_W];
  end

  // Pins with input disabled read as 0 and are excluded from edge detection.
  assign inVal = filt & ie_q;
  assign rise  = filt & ~prev_q & ie_q;
  assign fall  = ~filt & prev_q & ie_q;
  assign stSet = (rise & riseEn_q) | (fall & fallEn_q);
  assign stClr = (op == BUS_WRITE && bus.reg_addr == ADDR_STATUS) ? wdataN : '0;

  // A new event in the same cycle as a write-1-clear keeps the bit set.
  assign status_d = (status_q & ~stClr) | stSet;

  always_comb begin
    rdata_d = '0;
    case (bus.reg_addr)
      ADDR_OUT:     rdata_d[N-1:0] = out_q;
      ADDR_OEN:     rdata_d[N-1:0] = oen_q;
      ADDR_IE:      rdata_d[N-1:0] = ie_q;
      ADDR_IN:      rdata_d[N-1:0] = inVal;
      ADDR_RISE_EN: rdata_d[N-1:0] = riseEn_q;
      ADDR_FALL_EN: rdata_d[N-1:0] = fallEn_q;
      ADDR_STATUS:  rdata_d[N-1:0] = status_q;
      default: begin
        for (int i = 0; i < N; i++) begin
          if (bus.reg_addr == techAddr(i)) begin
            rdata_d[CFGW-1:0] = techCfg_q[i];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q    <= '0;
      oen_q    <= {N{OEN_RESET_BIT}};
      ie_q     <= '0;
      riseEn_q <= '0;
      fallEn_q <= '0;
      for (int i = 0; i < N; i++) begin
        techCfg_q[i] <= '0;
      end
    end else if (op == BUS_WRITE) begin
      case (bus.reg_addr)
        ADDR_OUT:     out_q    <= wdataN;
        ADDR_OEN:     oen_q    <= wdataN;
        ADDR_IE:      ie_q     <= wdataN;
        ADDR_RISE_EN: riseEn_q <= wdataN;
        ADDR_FALL_EN: fallEn_q <= wdataN;
        default: begin
          for (int i = 0; i < N; i++) begin
            if (bus.reg_addr == techAddr(i)) begin
              techCfg_q[i] <= bus.reg_wdata[CFGW-1:0];
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= '0;
      prev_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      prev_q   <= filt;
      irq_q    <= |status_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= (op == BUS_READ);
      if (op == BUS_READ) begin
        rdata_q <= rdata_d;
      end
    end
  end

  assign bus.reg_ready  = 1'b1;
  assign bus.reg_rvalid = rvalid_q;
  assign bus.reg_rdata  = rdata_q;
  assign pad_dout       = out_q;
  assign pad_oen        = oen_q;
  assign pad_ie         = ie_q;
  assign irq            = irq_q;

endmodule

// File: tb/tb_zerosoc_gpio_side.sv
// Self-checking bench for zerosoc_gpio_side (default build, GPIO_DEBOUNCE_EN undefined).
module tb_zerosoc_gpio_side;
  import zerosoc_gpio_pkg::*;

  localparam int N    = 9;
  localparam int CFGW = 16;

  typedef struct {
    bit          isWrite;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic [8:0]  expDout;
    logic [8:0]  expOen;
    logic [8:0]  expIe;
  } vec_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } rd_exp_t;

  logic              clk;
  logic              rst;
  logic [N-1:0]      pad_din;
  logic [N-1:0]      pad_dout;
  logic [N-1:0]      pad_oen;
  logic [N-1:0]      pad_ie;
  logic [N*CFGW-1:0] pad_tech_cfg;
  logic              irq;

  zerosoc_gpio_side_if bus ();

  zerosoc_gpio_side #(
    .N      (N),
    .CFGW   (CFGW),
    .DB_CYC (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .pad_din      (pad_din),
    .pad_dout     (pad_dout),
    .pad_oen      (pad_oen),
    .pad_ie       (pad_ie),
    .pad_tech_cfg (pad_tech_cfg),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int      checks = 0;
  int      errors = 0;
  rd_exp_t sb[$];
  vec_t    vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One clock: step past the edge, then settle any read response against the scoreboard.
  task automatic tick();
    rd_exp_t e;
    @(posedge clk);
    #1;
    if (bus.reg_rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL rvalid_unexpected: got 1, expected 0");
      end else begin
        e = sb.pop_front();
        checkOutput($sformatf("rdata@0x%0h", e.addr), bus.reg_rdata, e.data);
      end
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL rvalid_missing@0x%0h: got 0, expected 1", e.addr);
    end
  endtask

  task automatic applyStimulus(input bit isWrite, input logic [4:0] addr,
                               input logic [31:0] wdata, input logic [31:0] expRdata);
    bus.reg_valid = 1'b1;
    bus.reg_write = isWrite;
    bus.reg_addr  = addr;
    bus.reg_wdata = wdata;
    if (!isWrite) begin
      sb.push_back('{addr, expRdata});
    end
    tick();
    bus.reg_valid = 1'b0;
    bus.reg_write = 1'b0;
  endtask

  task automatic waitTicks(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    pad_din       = '0;
    bus.reg_valid = 1'b0;
    bus.reg_write = 1'b0;
    bus.reg_addr  = '0;
    bus.reg_wdata = '0;

    vecs.push_back('{1'b1, ADDR_OUT,     32'h0000_00A5, 32'h0,       9'h0A5, 9'h1FF, 9'h000});
    vecs.push_back('{1'b1, ADDR_OEN,     32'h0000_0100, 32'h0,       9'h0A5, 9'h100, 9'h000});
    vecs.push_back('{1'b0, ADDR_OUT,     32'h0,         32'h0A5,     9'h0A5, 9'h100, 9'h000});
    vecs.push_back('{1'b0, ADDR_OEN,     32'h0,         32'h100,     9'h0A5, 9'h100, 9'h000});
    vecs.push_back('{1'b1, ADDR_OUT,     32'hFFFF_FFFF, 32'h0,       9'h1FF, 9'h100, 9'h000});
    vecs.push_back('{1'b0, ADDR_OUT,     32'h0,         32'h1FF,     9'h1FF, 9'h100, 9'h000});
    vecs.push_back('{1'b1, ADDR_IE,      32'h0000_01FF, 32'h0,       9'h1FF, 9'h100, 9'h1FF});
    vecs.push_back('{1'b0, ADDR_IE,      32'h0,         32'h1FF,     9'h1FF, 9'h100, 9'h1FF});
    vecs.push_back('{1'b1, 5'h07,        32'h0000_1234, 32'h0,       9'h1FF, 9'h100, 9'h1FF});
    vecs.push_back('{1'b0, 5'h07,        32'h0,         32'h0,       9'h1FF, 9'h100, 9'h1FF});
    vecs.push_back('{1'b0, 5'h11,        32'h0,         32'h0,       9'h1FF, 9'h100, 9'h1FF});
    vecs.push_back('{1'b1, 5'h10,        32'h0000_BEEF, 32'h0,       9'h1FF, 9'h100, 9'h1FF});
    vecs.push_back('{1'b0, 5'h10,        32'h0,         32'hBEEF,    9'h1FF, 9'h100, 9'h1FF});
    vecs.push_back('{1'b1, 5'h08,        32'h1234_5678, 32'h0,       9'h1FF, 9'h100, 9'h1FF});
    vecs.push_back('{1'b0, 5'h08,        32'h0,         32'h5678,    9'h1FF, 9'h100, 9'h1FF});
    vecs.push_back('{1'b0, ADDR_IN,      32'h0,         32'h0,       9'h1FF, 9'h100, 9'h1FF});
    vecs.push_back('{1'b1, ADDR_RISE_EN, 32'h0000_0001, 32'h0,       9'h1FF, 9'h100, 9'h1FF});
    vecs.push_back('{1'b0, ADDR_RISE_EN, 32'h0,         32'h001,     9'h1FF, 9'h100, 9'h1FF});
    vecs.push_back('{1'b1, ADDR_FALL_EN, 32'h0000_0008, 32'h0,       9'h1FF, 9'h100, 9'h1FF});
    vecs.push_back('{1'b0, ADDR_FALL_EN, 32'h0,         32'h008,     9'h1FF, 9'h100, 9'h1FF});
    vecs.push_back('{1'b0, ADDR_STATUS,  32'h0,         32'h0,       9'h1FF, 9'h100, 9'h1FF});
    vecs.push_back('{1'b1, ADDR_OUT,     32'h0000_00A5, 32'h0,       9'h0A5, 9'h100, 9'h1FF});

    // Reset values
    waitTicks(2);
    checkOutput("rst_dout",   32'(pad_dout), 32'h0);
    checkOutput("rst_oen",    32'(pad_oen),  32'h1FF);
    checkOutput("rst_ie",     32'(pad_ie),   32'h0);
    checkOutput("rst_tech_lo", pad_tech_cfg[31:0],    32'h0);
    checkOutput("rst_tech_hi", 32'(pad_tech_cfg[143:128]), 32'h0);
    checkOutput("rst_irq",    32'(irq),      32'h0);
    checkOutput("rst_rvalid", 32'(bus.reg_rvalid), 32'h0);
    checkOutput("rst_rdata",  bus.reg_rdata, 32'h0);
    checkOutput("rst_ready",  32'(bus.reg_ready), 32'h1);
    rst = 1'b0;
    tick();

    // Register vectors
    for (int v = 0; v < vecs.size(); v++) begin
      applyStimulus(vecs[v].isWrite, vecs[v].addr, vecs[v].wdata, vecs[v].expRdata);
      checkOutput($sformatf("v%0d_dout", v), 32'(pad_dout), 32'(vecs[v].expDout));
      checkOutput($sformatf("v%0d_oen", v),  32'(pad_oen),  32'(vecs[v].expOen));
      checkOutput($sformatf("v%0d_ie", v),   32'(pad_ie),   32'(vecs[v].expIe));
    end
    checkOutput("tech_pad8", 32'(pad_tech_cfg[143:128]), 32'hBEEF);
    checkOutput("tech_pad0", 32'(pad_tech_cfg[15:0]),    32'h5678);
    checkOutput("tech_pad1", 32'(pad_tech_cfg[31:16]),   32'h0);

    // Rise on pin 0: STATUS after 3 edges, irq on the 4th, W1C drops irq
    pad_din[0] = 1'b1;
    waitTicks(3);
    checkOutput("rise_irq_e3", 32'(irq), 32'h0);
    applyStimulus(1'b0, ADDR_STATUS, 32'h0, 32'h001);
    checkOutput("rise_irq_e4", 32'(irq), 32'h1);
    applyStimulus(1'b0, ADDR_IN, 32'h0, 32'h001);
    applyStimulus(1'b1, ADDR_STATUS, 32'h1, 32'h0);
    checkOutput("w1c_irq_lag", 32'(irq), 32'h1);
    tick();
    checkOutput("w1c_irq_clr", 32'(irq), 32'h0);
    applyStimulus(1'b0, ADDR_STATUS, 32'h0, 32'h000);

    // Fall on pin 3 coincides with a W1C of bit 3: set wins
    pad_din[3] = 1'b1;
    waitTicks(4);
    applyStimulus(1'b0, ADDR_STATUS, 32'h0, 32'h000);
    pad_din[3] = 1'b0;
    waitTicks(2);
    applyStimulus(1'b1, ADDR_STATUS, 32'h8, 32'h0);
    applyStimulus(1'b0, ADDR_STATUS, 32'h0, 32'h008);
    checkOutput("fall_irq", 32'(irq), 32'h1);
    applyStimulus(1'b1, ADDR_STATUS, 32'h8, 32'h0);
    tick();
    checkOutput("fall_irq_clr", 32'(irq), 32'h0);

    // Input disabled on pin 2: reads 0 and raises no event
    applyStimulus(1'b1, ADDR_IE, 32'h1FB, 32'h0);
    applyStimulus(1'b1, ADDR_RISE_EN, 32'h005, 32'h0);
    pad_din[2] = 1'b1;
    waitTicks(5);
    applyStimulus(1'b0, ADDR_IN, 32'h0, 32'h001);
    applyStimulus(1'b0, ADDR_STATUS, 32'h0, 32'h000);
    checkOutput("ie_off_irq", 32'(irq), 32'h0);
    checkOutput("ie_off_pad_ie", 32'(pad_ie), 32'h1FB);

    // Disabling RISE_EN leaves a pending STATUS bit in place
    pad_din[0] = 1'b0;
    waitTicks(4);
    applyStimulus(1'b0, ADDR_STATUS, 32'h0, 32'h000);
    pad_din[0] = 1'b1;
    waitTicks(4);
    applyStimulus(1'b1, ADDR_RISE_EN, 32'h0, 32'h0);
    applyStimulus(1'b0, ADDR_STATUS, 32'h0, 32'h001);
    checkOutput("pend_irq", 32'(irq), 32'h1);

    // Asynchronous reset mid-operation
    rst = 1'b1;
    #2;
    checkOutput("mid_rst_dout", 32'(pad_dout), 32'h0);
    checkOutput("mid_rst_oen",  32'(pad_oen),  32'h1FF);
    checkOutput("mid_rst_ie",   32'(pad_ie),   32'h0);
    checkOutput("mid_rst_tech", 32'(pad_tech_cfg[143:128]), 32'h0);
    checkOutput("mid_rst_irq",  32'(irq),      32'h0);
    rst = 1'b0;
    tick();
    applyStimulus(1'b0, ADDR_STATUS, 32'h0, 32'h000);
    applyStimulus(1'b0, ADDR_OEN, 32'h0, 32'h1FF);
    applyStimulus(1'b0, 5'h08, 32'h0, 32'h0);
    tick();
    checkOutput("sb_drained", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
